// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling from a 2-flop synchronized line,
// one-entry holding register with valid/ready handoff, frame-error and overrun pulses.
module uart_rx #(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 115200
) (
    input  logic       clk_100mhz,
    input  logic       sys_rst_i,
    input  logic       terminal_rx,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       busy_o
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic          r_sync1, r_sync2;
    state_t        r_state, w_state_next;
    logic [CW-1:0] r_cnt, w_cnt_next;
    logic [2:0]    r_idx, w_idx_next;
    logic [7:0]    r_shift, w_shift_next;
    logic [7:0]    r_data;
    logic          r_valid, r_ferr, r_ovr;
    logic          w_good, w_bad, w_load;

    always_ff @(posedge clk_100mhz) begin
        if (sys_rst_i) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
        end else begin
            r_sync1 <= terminal_rx;
            r_sync2 <= r_sync1;
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_idx   <= w_idx_next;
            r_shift <= w_shift_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_idx_next   = r_idx;
        w_shift_next = r_shift;
        w_good       = 1'b0;
        w_bad        = 1'b0;
        case (r_state)
            IDLE: begin
                if (!r_sync2) begin
                    w_state_next = START;
                    w_cnt_next   = '0;
                end
            end
            START: begin
                // A start bit that is high again at its midpoint is treated as a glitch.
                if (r_cnt == CNT_HALF) begin
                    w_cnt_next   = '0;
                    w_idx_next   = '0;
                    w_state_next = r_sync2 ? IDLE : DATA;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            DATA: begin
                if (r_cnt == CNT_LAST) begin
                    w_shift_next[r_idx] = r_sync2;
                    w_cnt_next          = '0;
                    w_idx_next          = r_idx + 3'd1;
                    if (r_idx == 3'd7) begin
                        w_state_next = STOP;
                    end
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            STOP: begin
                if (r_cnt == CNT_LAST) begin
                    w_good       = r_sync2;
                    w_bad        = ~r_sync2;
                    w_cnt_next   = '0;
                    w_state_next = IDLE;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // A new byte may replace the held one only in the same cycle it is being accepted.
    assign w_load = w_good & (~r_valid | rx_ready_i);

    always_ff @(posedge clk_100mhz) begin
        if (sys_rst_i) begin
            r_data  <= 8'h00;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_ferr <= w_bad;
            r_ovr  <= w_good & r_valid & ~rx_ready_i;
            if (w_load) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (r_valid && rx_ready_i) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_data_o   = r_data;
    assign rx_valid_o  = r_valid;
    assign frame_err_o = r_ferr;
    assign overrun_o   = r_ovr;
    assign busy_o      = (r_state != IDLE);
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQ, default 100000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, serial bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer division, 868 at defaults).
REQ-003 clk_100mhz  input  1  system clock; all logic on its rising edge.
REQ-004 sys_rst_i  input  1  reset; synchronous, active-high.
REQ-005 terminal_rx  input  1  asynchronous serial line from terminal, idle high, 8N1 framing, LSB first.
REQ-006 rx_data_o  output  8  received byte; valid only while rx_valid_o=1.
REQ-007 rx_valid_o  output  1  byte available; held until accepted.
REQ-008 rx_ready_i  input  1  consumer accepts byte; transfer occurs on the cycle where rx_valid_o=1 and rx_ready_i=1.
REQ-009 frame_err_o  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 overrun_o  output  1  one-cycle pulse: completed byte dropped because the holding register was full.
REQ-011 busy_o  output  1  high whenever the FSM is not in IDLE.

Function
REQ-012 terminal_rx SHALL pass through a 2-flop synchronizer; both flops reset to 1; all FSM decisions use the second flop (rx_s).
REQ-013 FSM states: IDLE, START, DATA, STOP; one cycle counter (width ceil(log2(CLKS_PER_BIT))) and 3-bit bit index.
REQ-014 IDLE: rx_s=0 -> START with counter=0; otherwise remain.
REQ-015 START: counter increments each cycle; at counter=CLKS_PER_BIT/2-1 (433) sample rx_s: 0 -> DATA, counter=0, index=0; 1 -> IDLE (glitch rejected, no flags).
REQ-016 DATA: at counter=CLKS_PER_BIT-1 (867) sample rx_s into bit[index] of a shift register, clear counter, increment index; after index 7 is sampled -> STOP.
REQ-017 STOP: at counter=CLKS_PER_BIT-1 sample rx_s; 1 -> good frame; 0 -> frame_err_o=1 for the next cycle, byte discarded; either way -> IDLE on the same edge (next start is detectable immediately).
REQ-018 Good frame, holding register empty (rx_valid_o=0): rx_data_o loaded, rx_valid_o=1 on the next cycle.
REQ-019 Good frame while rx_valid_o=1 and rx_ready_i=1 in that cycle: new byte loaded, rx_valid_o stays 1, no overrun.
REQ-020 Good frame while rx_valid_o=1 and rx_ready_i=0: new byte dropped, rx_data_o unchanged, overrun_o=1 for one cycle.
REQ-021 rx_valid_o=1 and rx_ready_i=1 with no simultaneous good frame -> rx_valid_o=0 next cycle; rx_data_o holds its last value.
REQ-022 rx_data_o SHALL not change while rx_valid_o=1 except per REQ-019.
REQ-023 Latency: rx_valid_o rises 8249 +/-1 clocks after the terminal_rx falling edge of the start bit (2 sync + 434 + 8*868 + 868 + 1).
REQ-024 frame_err_o and overrun_o SHALL never be high for more than one consecutive cycle per frame and never both in the same cycle.
REQ-025 busy_o is combinational from state (state != IDLE).

Reset
REQ-026 While sys_rst_i=1 on a clock edge: state=IDLE, counter=0, index=0, shift register=0, synchronizer flops=1.
REQ-027 Output reset values: rx_data_o=8'h00, rx_valid_o=0, frame_err_o=0, overrun_o=0, busy_o=0.
REQ-028 Reset asserted mid-frame aborts the frame with no valid, error or overrun pulse; the remaining bits of that frame after reset release are treated as line activity from IDLE.

Verification
REQ-029 Reset held 10 cycles with terminal_rx=1 -> all outputs 0; after release, 20000 idle cycles -> busy_o, rx_valid_o remain 0.
REQ-030 Send 0xA5 at 8680 ns/bit, rx_ready_i=1 -> rx_valid_o high exactly 1 cycle, rx_data_o=8'hA5, within 8249+/-1 clocks of start edge; no error pulses.
REQ-031 rx_ready_i=0, send 0x3C then 0x55 back-to-back -> rx_valid_o stays 1 with 8'h3C, overrun_o pulses once after second stop bit; then rx_ready_i=1 for 1 cycle -> rx_valid_o=0, rx_data_o stays 8'h3C.
REQ-032 Send 0xFF with stop bit driven 0 -> frame_err_o one-cycle pulse, rx_valid_o stays 0; following valid 0x12 frame received correctly.
REQ-033 terminal_rx low pulse of 200 cycles -> busy_o high then low by cycle ~436, no valid/error/overrun.
REQ-034 sys_rst_i=1 for 1 cycle during bit 4 of a 0x81 frame -> busy_o=0 next cycle, no rx_valid_o for that frame.
